// File: rtl/alu_seq.sv
// alu_seq: execute-stage ALU. Single-cycle ADD/SUB/AND/OR/XOR/CMP plus
// iterative MUL (shift-add) and DIV (restoring), one op per start request,
// with a start/busy/done handshake and registered result/flags.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ena,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_dz
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int M  = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;   // MUL: multiplicand; DIV: dividend shifting into quotient
  logic [WIDTH-1:0] opb;   // MUL: multiplier shifting into product low half; DIV: divisor
  logic [WIDTH-1:0] acc;   // MUL: product high half; DIV: partial remainder
  logic [CW-1:0]    cnt;

  // Single-cycle datapath, extra top bit carries the carry / borrow
  logic [WIDTH:0] add_w, sub_w;
  logic           add_v, sub_v;
  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};
  assign add_v = (a[M] == b[M]) && (add_w[M] != a[M]);
  assign sub_v = (a[M] != b[M]) && (sub_w[M] != a[M]);

  // Shift-add step: conditionally add multiplicand to the high half, then
  // shift {acc, opb} right so the product low bits replace used multiplier bits
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt;
  assign mul_sum    = {1'b0, acc} + (opb[0] ? {1'b0, opa} : '0);
  assign mul_hi_nxt = mul_sum[WIDTH:1];
  assign mul_lo_nxt = {mul_sum[0], opb[WIDTH-1:1]};

  // Restoring divide step: remainder < divisor keeps both branches in WIDTH bits
  logic [WIDTH:0]   div_sh, div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_nxt, div_q_nxt;
  assign div_sh      = {acc, opa[M]};
  assign div_ge      = div_sh >= {1'b0, opb};
  assign div_sub     = div_sh - {1'b0, opb};
  assign div_rem_nxt = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign div_q_nxt   = {opa[M-1:0], div_ge};

  // Control FSM and all registered outputs; ena=0 freezes everything
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      opa       <= '0;
      opb       <= '0;
      acc       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      flag_dz   <= 1'b0;
    end else if (ena) begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          case (alu_op)
            OP_ADD: begin
              result <= add_w[M:0]; result_hi <= '0;
              flag_z <= (add_w[M:0] == '0); flag_c <= add_w[WIDTH];
              flag_v <= add_v; flag_dz <= 1'b0; done <= 1'b1;
            end
            OP_SUB: begin
              result <= sub_w[M:0]; result_hi <= '0;
              flag_z <= (sub_w[M:0] == '0); flag_c <= sub_w[WIDTH];
              flag_v <= sub_v; flag_dz <= 1'b0; done <= 1'b1;
            end
            OP_CMP: begin
              // flags only; result and result_hi keep the previous op
              flag_z <= (sub_w[M:0] == '0); flag_c <= sub_w[WIDTH];
              flag_v <= sub_v; flag_dz <= 1'b0; done <= 1'b1;
            end
            OP_AND: begin
              result <= a & b; result_hi <= '0; flag_z <= ((a & b) == '0);
              flag_c <= 1'b0; flag_v <= 1'b0; flag_dz <= 1'b0; done <= 1'b1;
            end
            OP_OR: begin
              result <= a | b; result_hi <= '0; flag_z <= ((a | b) == '0);
              flag_c <= 1'b0; flag_v <= 1'b0; flag_dz <= 1'b0; done <= 1'b1;
            end
            OP_XOR: begin
              result <= a ^ b; result_hi <= '0; flag_z <= ((a ^ b) == '0);
              flag_c <= 1'b0; flag_v <= 1'b0; flag_dz <= 1'b0; done <= 1'b1;
            end
            OP_MUL: begin
              opa <= a; opb <= b; acc <= '0; cnt <= CW'(WIDTH);
              busy <= 1'b1; state <= MUL_RUN;
            end
            default: begin // OP_DIV
              if (b == '0) begin
                // divide by zero resolves immediately, no iteration
                result <= '1; result_hi <= a; flag_z <= 1'b0; flag_c <= 1'b0;
                flag_v <= 1'b0; flag_dz <= 1'b1; done <= 1'b1;
              end else begin
                opa <= a; opb <= b; acc <= '0; cnt <= CW'(WIDTH);
                busy <= 1'b1; state <= DIV_RUN;
              end
            end
          endcase
        end
        MUL_RUN: begin
          acc <= mul_hi_nxt;
          opb <= mul_lo_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            result    <= mul_lo_nxt;
            result_hi <= mul_hi_nxt;
            flag_z    <= ({mul_hi_nxt, mul_lo_nxt} == '0);
            flag_c    <= (mul_hi_nxt != '0);
            flag_v    <= 1'b0;
            flag_dz   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        DIV_RUN: begin
          acc <= div_rem_nxt;
          opa <= div_q_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            result    <= div_q_nxt;
            result_hi <= div_rem_nxt;
            flag_z    <= (div_q_nxt == '0);
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            flag_dz   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq (WIDTH=8).
module tb_alu_seq;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
  localparam logic [2:0] XOR_ = 3'b100, MUL = 3'b101, DIV = 3'b110, CMP = 3'b111;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       ena = 1'b1;
  logic       start = 1'b0;
  logic [2:0] alu_op = 3'b000;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic       busy, done, flag_z, flag_c, flag_v, flag_dz;
  logic [7:0] result, result_hi;

  int cmp_cnt = 0;
  int err_cnt = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .ena(ena), .start(start), .alu_op(alu_op),
    .a(a), .b(b), .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .flag_dz(flag_dz)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // present one request across a single edge
  task automatic issue(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    alu_op = op; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // edges until done is seen, -1 on timeout
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1; #2 reset_n = 1'b0; #1;
    cmp_cnt++; if ({busy, done, flag_z, flag_c, flag_v, flag_dz} !== 6'b0) begin err_cnt++; $display("FAIL reset_ctl got=%b exp=000000", {busy, done, flag_z, flag_c, flag_v, flag_dz}); end
    cmp_cnt++; if ({result, result_hi} !== 16'h0000) begin err_cnt++; $display("FAIL reset_res got=%h exp=0000", {result, result_hi}); end
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    issue(ADD, 8'hFF, 8'h01);
    cmp_cnt++; if (done !== 1'b1 || busy !== 1'b0) begin err_cnt++; $display("FAIL add_hs got done=%b busy=%b exp done=1 busy=0", done, busy); end
    cmp_cnt++; if (result !== 8'h00 || result_hi !== 8'h00) begin err_cnt++; $display("FAIL add_res got=%h/%h exp=00/00", result_hi, result); end
    cmp_cnt++; if ({flag_z, flag_c, flag_v} !== 3'b110) begin err_cnt++; $display("FAIL add_flags got zcv=%b exp=110", {flag_z, flag_c, flag_v}); end
    tick();
    cmp_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL add_done_clr got=%b exp=0", done); end
    issue(ADD, 8'h7F, 8'h01);
    cmp_cnt++; if (result !== 8'h80 || {flag_z, flag_c, flag_v} !== 3'b001) begin err_cnt++; $display("FAIL add_ovf got=%h zcv=%b exp=80 zcv=001", result, {flag_z, flag_c, flag_v}); end
    tick();
  endtask

  task automatic test_sub_cmp();
    issue(SUB, 8'h80, 8'h01);
    cmp_cnt++; if (result !== 8'h7F || {flag_z, flag_c, flag_v} !== 3'b001) begin err_cnt++; $display("FAIL sub_ovf got=%h zcv=%b exp=7f zcv=001", result, {flag_z, flag_c, flag_v}); end
    tick();
    issue(CMP, 8'h05, 8'h07);
    cmp_cnt++; if (done !== 1'b1 || {flag_z, flag_c, flag_v} !== 3'b010) begin err_cnt++; $display("FAIL cmp_flags got done=%b zcv=%b exp done=1 zcv=010", done, {flag_z, flag_c, flag_v}); end
    cmp_cnt++; if (result !== 8'h7F) begin err_cnt++; $display("FAIL cmp_hold got=%h exp=7f", result); end
    tick();
    issue(AND_, 8'hF0, 8'h0F);
    cmp_cnt++; if (result !== 8'h00 || flag_z !== 1'b1) begin err_cnt++; $display("FAIL and_zero got=%h z=%b exp=00 z=1", result, flag_z); end
    tick();
    issue(OR_, 8'hF0, 8'h0C);
    cmp_cnt++; if (result !== 8'hFC || flag_z !== 1'b0) begin err_cnt++; $display("FAIL or_res got=%h z=%b exp=fc z=0", result, flag_z); end
    tick();
  endtask

  task automatic test_mul();
    int n;
    logic seen_busy_drop;
    issue(MUL, 8'h0F, 8'h11);
    cmp_cnt++; if (busy !== 1'b1 || done !== 1'b0) begin err_cnt++; $display("FAIL mul_accept got busy=%b done=%b exp busy=1 done=0", busy, done); end
    seen_busy_drop = 1'b0;
    for (int i = 0; i < 7; i++) begin tick(); if (busy !== 1'b1 || done !== 1'b0) seen_busy_drop = 1'b1; end
    cmp_cnt++; if (seen_busy_drop !== 1'b0) begin err_cnt++; $display("FAIL mul_busy_hold got early_end=1 exp=0"); end
    tick();
    cmp_cnt++; if (done !== 1'b1 || busy !== 1'b0) begin err_cnt++; $display("FAIL mul_lat8 got done=%b busy=%b exp done=1 busy=0", done, busy); end
    cmp_cnt++; if ({result_hi, result} !== 16'h00FF || flag_c !== 1'b0) begin err_cnt++; $display("FAIL mul_0f11 got=%h c=%b exp=00ff c=0", {result_hi, result}, flag_c); end
    tick();
    issue(MUL, 8'hFF, 8'hFF); wait_done(n);
    cmp_cnt++; if (n !== 8 || {result_hi, result} !== 16'hFE01 || flag_c !== 1'b1) begin err_cnt++; $display("FAIL mul_ffff got lat=%0d res=%h c=%b exp lat=8 res=fe01 c=1", n, {result_hi, result}, flag_c); end
    tick();
    issue(MUL, 8'h00, 8'h37); wait_done(n);
    cmp_cnt++; if ({result_hi, result} !== 16'h0000 || flag_z !== 1'b1) begin err_cnt++; $display("FAIL mul_zero got=%h z=%b exp=0000 z=1", {result_hi, result}, flag_z); end
    tick();
  endtask

  task automatic test_div();
    int n;
    issue(DIV, 8'd200, 8'd7); wait_done(n);
    cmp_cnt++; if (n !== 8) begin err_cnt++; $display("FAIL div_lat got=%0d exp=8", n); end
    cmp_cnt++; if (result !== 8'h1C || result_hi !== 8'h04 || flag_dz !== 1'b0) begin err_cnt++; $display("FAIL div_200_7 got=%h r=%h dz=%b exp=1c r=04 dz=0", result, result_hi, flag_dz); end
    tick();
    issue(DIV, 8'h42, 8'h00);
    cmp_cnt++; if (done !== 1'b1 || busy !== 1'b0) begin err_cnt++; $display("FAIL dz_hs got done=%b busy=%b exp done=1 busy=0", done, busy); end
    cmp_cnt++; if (result !== 8'hFF || result_hi !== 8'h42 || {flag_z, flag_c, flag_v, flag_dz} !== 4'b0001) begin err_cnt++; $display("FAIL dz_res got=%h r=%h zcvd=%b exp=ff r=42 zcvd=0001", result, result_hi, {flag_z, flag_c, flag_v, flag_dz}); end
    tick();
    issue(ADD, 8'h01, 8'h01);
    cmp_cnt++; if (flag_dz !== 1'b0 || result !== 8'h02) begin err_cnt++; $display("FAIL dz_clear got dz=%b res=%h exp dz=0 res=02", flag_dz, result); end
    tick();
  endtask

  task automatic test_stall_reset();
    int n;
    logic bad;
    issue(MUL, 8'h12, 8'h34);
    // re-pulse start with new operands while busy (edge 1), then edge 2
    alu_op = MUL; a = 8'h02; b = 8'h02; start = 1'b1; tick(); start = 1'b0;
    tick();
    ena = 1'b0; bad = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1; end
    cmp_cnt++; if (bad !== 1'b0) begin err_cnt++; $display("FAIL stall_hold got change=1 exp=0"); end
    ena = 1'b1;
    wait_done(n);
    cmp_cnt++; if (n + 5 !== 11) begin err_cnt++; $display("FAIL stall_lat got=%0d exp=11", n + 5); end
    cmp_cnt++; if ({result_hi, result} !== 16'h03A8) begin err_cnt++; $display("FAIL busy_ignore got=%h exp=03a8", {result_hi, result}); end
    ena = 1'b0; tick();
    cmp_cnt++; if (done !== 1'b1) begin err_cnt++; $display("FAIL stall_done_hold got=%b exp=1", done); end
    ena = 1'b1; tick();
    cmp_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL done_clear got=%b exp=0", done); end
    // async reset in the middle of a DIV
    issue(DIV, 8'd200, 8'd7);
    tick(); tick(); tick();
    #2 reset_n = 1'b0; #1;
    cmp_cnt++; if ({busy, done, flag_z, flag_c, flag_v, flag_dz, result, result_hi} !== 22'h0) begin err_cnt++; $display("FAIL rst_mid got busy=%b done=%b res=%h hi=%h exp all 0", busy, done, result, result_hi); end
    tick();
    reset_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin tick(); if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1; end
    cmp_cnt++; if (bad !== 1'b0) begin err_cnt++; $display("FAIL rst_no_done got activity=1 exp=0"); end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(DIV, 8'd200, 8'd7); wait_done(n);
    cmp_cnt++; if (n !== 8 || result !== 8'h1C) begin err_cnt++; $display("FAIL b2b_div got lat=%0d res=%h exp lat=8 res=1c", n, result); end
    issue(XOR_, 8'hAA, 8'h0F);
    cmp_cnt++; if (done !== 1'b1 || result !== 8'hA5 || result_hi !== 8'h00) begin err_cnt++; $display("FAIL b2b_xor got done=%b res=%h hi=%h exp done=1 res=a5 hi=00", done, result, result_hi); end
    issue(MUL, 8'h02, 8'h03);
    cmp_cnt++; if (done !== 1'b0 || busy !== 1'b1) begin err_cnt++; $display("FAIL b2b_mul_acc got done=%b busy=%b exp done=0 busy=1", done, busy); end
    wait_done(n);
    cmp_cnt++; if (n !== 8 || {result_hi, result} !== 16'h0006) begin err_cnt++; $display("FAIL b2b_mul got lat=%0d res=%h exp lat=8 res=0006", n, {result_hi, result}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_cmp();
    test_mul();
    test_div();
    test_stall_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
